// File: rtl/instr_fetch_4bit.sv
// Instruction fetch/issue stage: program memory, PC and a valid/ready issue port to the core.
// Define IFETCH_STEP_EN to add a single-step input that gates FETCH -> ISSUE.
module instr_fetch_4bit #(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int ARG_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [OP_W+ARG_W-1:0] prog_data,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_addr,
`ifdef IFETCH_STEP_EN
    input  logic                  step,
`endif
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [OP_W-1:0]       cmd_op,
    output logic [ARG_W-1:0]      cmd_operand,
    output logic [ADDR_W-1:0]     cmd_pc,
    output logic                  busy,
    output logic                  halted
);

    // state  | meaning
    // IDLE   | waiting for start after reset, memory writable
    // FETCH  | reading mem[pc] into the cmd_* registers
    // ISSUE  | cmd_valid high, waiting for cmd_ready
    // HALT   | HLT consumed, memory writable, start restarts
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int WORD_W = OP_W + ARG_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic                load_cmd;
    logic                handshake;
    logic                fetch_go;
    logic                prog_en;
    logic [WORD_W-1:0]   mem [DEPTH];

`ifdef IFETCH_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign cmd_valid = (state == S_ISSUE);
    assign handshake = cmd_valid & cmd_ready;
    assign busy      = (state == S_FETCH) || (state == S_ISSUE);
    assign halted    = (state == S_HALT);
    assign prog_en   = (state == S_IDLE) || (state == S_HALT);

    // Memory is deliberately outside the reset domain so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (prog_we && prog_en) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load_cmd  = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nxt    = start_addr;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_addr;
                end else if (fetch_go) begin
                    load_cmd  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Redirect wins over both the increment and HLT; a pending word is dropped.
                if (redirect_valid) begin
                    pc_nxt    = redirect_addr;
                    state_nxt = S_FETCH;
                end else if (handshake) begin
                    if (cmd_op == {OP_W{1'b1}}) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = pc + ADDR_W'(1);
                        state_nxt = S_FETCH;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            cmd_op      <= '0;
            cmd_operand <= '0;
            cmd_pc      <= '0;
        end else begin
            pc <= pc_nxt;
            if (load_cmd) begin
                {cmd_op, cmd_operand} <= mem[pc];
                cmd_pc                <= pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_4bit.sv
// Bench for instr_fetch_4bit: directed program scenarios plus randomized runs against a transaction-level model.
module tb_instr_fetch_4bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic [3:0] start_addr;
    logic       redirect_valid;
    logic [3:0] redirect_addr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_operand;
    logic [3:0] cmd_pc;
    logic       busy;
    logic       halted;

    always #5 clk = ~clk;

    instr_fetch_4bit dut (
        .clk            (clk),
        .reset          (reset),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .start          (start),
        .start_addr     (start_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
`ifdef IFETCH_STEP_EN
        .step           (1'b1),
`endif
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_operand    (cmd_operand),
        .cmd_pc         (cmd_pc),
        .busy           (busy),
        .halted         (halted)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference: program image, PC, and whether the stage is running or halted.
    logic [7:0]  m_mem [16];
    logic [3:0]  m_pc;
    bit          m_run;
    bit          m_halt;
    bit          have_hold;
    logic [12:0] hold_snap;

    logic [3:0] hs_pc_q[$];
    logic [3:0] hs_op_q[$];
    int         hs_cyc_q[$];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic clear_log();
        hs_pc_q.delete();
        hs_op_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic step_cycle();
        bit hs;
        @(negedge clk);
        cyc++;
        hs = cmd_valid && cmd_ready;
        if (have_hold)
            check_eq("hold_stable", {cmd_valid, cmd_pc, cmd_op, cmd_operand}, hold_snap);
        check_eq("busy", busy, m_run);
        check_eq("halted", halted, m_halt);
        if (!m_run) check_eq("valid_when_stopped", cmd_valid, 0);
        if (hs) begin
            hs_pc_q.push_back(cmd_pc);
            hs_op_q.push_back(cmd_op);
            hs_cyc_q.push_back(cyc);
            check_eq("issue_pc", cmd_pc, m_pc);
            check_eq("issue_word", {cmd_op, cmd_operand}, m_mem[m_pc]);
        end
        have_hold = cmd_valid && !cmd_ready && !redirect_valid;
        hold_snap = {cmd_valid, cmd_pc, cmd_op, cmd_operand};
        if (prog_we && !m_run) m_mem[prog_addr] = prog_data;
        if (!m_run) begin
            if (start) begin
                m_pc   = start_addr;
                m_run  = 1'b1;
                m_halt = 1'b0;
            end
        end else if (redirect_valid) begin
            m_pc = redirect_addr;
        end else if (hs) begin
            if (m_mem[m_pc][7:4] == 4'hF) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_pc = m_pc + 4'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prog_we        = 1'b0;
        prog_addr      = '0;
        prog_data      = '0;
        start          = 1'b0;
        start_addr     = '0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        cmd_ready      = 1'b1;
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b0;
        #1;
        if (chk) begin
            check_eq("rst_valid", cmd_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_halted", halted, 0);
            check_eq("rst_cmd", {cmd_op, cmd_operand, cmd_pc}, 0);
        end
        m_run     = 1'b0;
        m_halt    = 1'b0;
        have_hold = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step_cycle();
        prog_we = 1'b0;
    endtask

    task automatic start_at(input logic [3:0] a);
        start      = 1'b1;
        start_addr = a;
        step_cycle();
        start = 1'b0;
    endtask

    task automatic load_base();
        load_word(4'd0, 8'h00);
        load_word(4'd1, 8'h50);
        load_word(4'd2, 8'h40);
        load_word(4'd3, 8'hF0);
    endtask

    initial begin
        logic [3:0] exp_op [4];
        int         start_cyc;
        int         hold_n;
        bit         fired;
        exp_op = '{4'h0, 4'h5, 4'h4, 4'hF};
        idle_inputs();
        m_pc      = '0;
        m_run     = 1'b0;
        m_halt    = 1'b0;
        have_hold = 1'b0;
        reset     = 1'b1;
        #2;
        do_reset(1'b1);
        for (int a = 0; a < 16; a++) load_word(4'(a), 8'($urandom_range(0, 239)));

        // Straight-line program ending in HLT
        load_base();
        clear_log();
        start_cyc = cyc + 1;
        start_at(4'd0);
        for (int k = 0; k < 20; k++) step_cycle();
        check_eq("t1_count", hs_pc_q.size(), 4);
        for (int i = 0; i < hs_pc_q.size() && i < 4; i++) begin
            check_eq("t1_op", hs_op_q[i], exp_op[i]);
            check_eq("t1_pc", hs_pc_q[i], i);
            if (i > 0) check_eq("t1_gap", hs_cyc_q[i] - hs_cyc_q[i-1], 2);
        end
        if (hs_cyc_q.size() > 0) check_eq("t1_latency", hs_cyc_q[0] - start_cyc, 2);
        check_eq("t1_halted", halted, 1);
        check_eq("t1_valid_after", cmd_valid, 0);

        // Backpressure on PC=1 for 5 cycles
        do_reset(1'b0);
        clear_log();
        hold_n = 0;
        start_at(4'd0);
        for (int k = 0; k < 30 && !halted; k++) begin
            cmd_ready = !(cmd_valid && cmd_pc == 4'd1 && hold_n < 5);
            if (!cmd_ready) hold_n++;
            step_cycle();
        end
        cmd_ready = 1'b1;
        check_eq("t2_held", hold_n, 5);
        check_eq("t2_count", hs_pc_q.size(), 4);
        for (int i = 0; i < hs_pc_q.size(); i++) check_eq("t2_pc", hs_pc_q[i], i);

        // Redirect with handshake (JNZ at PC=2 -> 6)
        do_reset(1'b0);
        load_word(4'd2, 8'h86);
        load_word(4'd6, 8'hF0);
        clear_log();
        start_at(4'd0);
        for (int k = 0; k < 30 && !halted; k++) begin
            redirect_valid = cmd_valid && cmd_pc == 4'd2;
            redirect_addr  = 4'd6;
            step_cycle();
        end
        redirect_valid = 1'b0;
        check_eq("t3_count", hs_pc_q.size(), 4);
        if (hs_pc_q.size() >= 4) check_eq("t3_target", hs_pc_q[3], 6);

        // Redirect without handshake drops the pending word
        do_reset(1'b0);
        load_word(4'd9, 8'hF0);
        clear_log();
        fired = 1'b0;
        start_at(4'd0);
        for (int k = 0; k < 30 && !halted; k++) begin
            redirect_valid = !fired && cmd_valid && cmd_pc == 4'd1;
            redirect_addr  = 4'd9;
            cmd_ready      = !redirect_valid;
            step_cycle();
            if (redirect_valid) begin
                fired = 1'b1;
                check_eq("t4_drop_valid", cmd_valid, 0);
            end
            redirect_valid = 1'b0;
            cmd_ready      = 1'b1;
        end
        check_eq("t4_count", hs_pc_q.size(), 2);
        if (hs_pc_q.size() >= 2) check_eq("t4_target", hs_pc_q[1], 9);

        // PC wrap from 15 and reset while ISSUE is pending
        do_reset(1'b0);
        load_word(4'd15, 8'h50);
        load_word(4'd2, 8'h40);
        clear_log();
        start_at(4'd15);
        for (int k = 0; k < 20 && hs_pc_q.size() < 2; k++) step_cycle();
        check_eq("t5_count", hs_pc_q.size(), 2);
        if (hs_pc_q.size() >= 2) check_eq("t5_wrap_pc", hs_pc_q[1], 0);
        cmd_ready = 1'b0;
        for (int k = 0; k < 10 && !cmd_valid; k++) step_cycle();
        check_eq("t5_in_issue", cmd_valid, 1);
        do_reset(1'b1);

        // Program write during ISSUE is ignored; restart from HALT
        clear_log();
        start_at(4'd0);
        fired = 1'b0;
        for (int k = 0; k < 30 && !halted; k++) begin
            prog_we   = !fired && cmd_valid && cmd_pc == 4'd0;
            prog_addr = 4'd1;
            prog_data = 8'hF0;
            if (prog_we) fired = 1'b1;
            step_cycle();
            prog_we = 1'b0;
        end
        check_eq("t6_count", hs_op_q.size(), 4);
        if (hs_op_q.size() >= 2) check_eq("t6_old_word", hs_op_q[1], 5);
        check_eq("t6_halted", halted, 1);
        clear_log();
        start_at(4'd0);
        check_eq("t6_halt_clear", halted, 0);
        for (int k = 0; k < 20 && !halted; k++) step_cycle();
        if (hs_pc_q.size() > 0) check_eq("t6_rerun_pc", hs_pc_q[0], 0);
        check_eq("t6_rerun_count", hs_pc_q.size(), 4);

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            do_reset(1'b0);
            for (int a = 0; a < 16; a++)
                load_word(4'(a), ($urandom_range(0, 3) == 0) ? {4'hF, 4'($urandom)} : 8'($urandom_range(0, 239)));
            clear_log();
            for (int k = 0; k < 60; k++) begin
                cmd_ready      = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 7) == 0);
                redirect_addr  = 4'($urandom);
                prog_we        = ($urandom_range(0, 5) == 0);
                prog_addr      = 4'($urandom);
                prog_data      = 8'($urandom);
                start          = (k == 0) || ($urandom_range(0, 9) == 0);
                start_addr     = 4'($urandom);
                step_cycle();
            end
            idle_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_4bit.md
Name: instr_fetch_4bit

Overview:
Instruction fetch/issue stage directly upstream of the 4-bit computer core. Holds a small loadable program memory of {opcode, operand} words and a program counter. Presents one instruction at a time to the core over a valid/ready handshake. Accepts PC redirects from the core for JNZ/CALL/RET and stops after issuing HLT (opcode 15).

Parameters:
ADDR_W, 4, program address width; memory depth = 2**ADDR_W words
OP_W, 4, opcode width (core command encoding 0..15)
ARG_W, 4, operand width (ADDRESS/immediate field)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
prog_we  input  1  program memory write enable
prog_addr  input  ADDR_W  program memory write address
prog_data  input  OP_W+ARG_W  write data, {opcode, operand}
start  input  1  start pulse
start_addr  input  ADDR_W  initial PC taken on start
redirect_valid  input  1  core requests PC change
redirect_addr  input  ADDR_W  new PC
cmd_valid  output  1  instruction on cmd_* is valid
cmd_ready  input  1  core accepts instruction
cmd_op  output  OP_W  opcode
cmd_operand  output  ARG_W  operand
cmd_pc  output  ADDR_W  address the instruction came from
busy  output  1  high in FETCH or ISSUE
halted  output  1  high in HALT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, PC=0, cmd_valid=0, cmd_op=0, cmd_operand=0, cmd_pc=0, busy=0, halted=0.
- Reset has no effect on memory contents. An in-flight instruction is discarded immediately.
- FSM states: IDLE, FETCH, ISSUE, HALT.
- Memory has a synchronous read. prog_we is honoured only in IDLE and HALT; it is ignored in FETCH and ISSUE.
- IDLE: a start pulse loads PC=start_addr and moves to FETCH. If prog_we and start occur in the same cycle, the write completes and the following fetch sees the new data.
- FETCH (1 cycle): reads mem[PC] and registers cmd_op, cmd_operand and cmd_pc=PC. Next state is ISSUE with cmd_valid=1.
- ISSUE: cmd_* stay stable while cmd_valid=1 and cmd_ready=0.
  - On a handshake (cmd_valid & cmd_ready) with cmd_op==15: go to HALT and drop cmd_valid.
  - On a handshake with any other opcode: PC=PC+1, wrapping 2**ADDR_W-1 to 0, and go to FETCH. cmd_valid is 0 during FETCH.
- Throughput is at most one instruction per 2 cycles. Latency from start to the first cmd_valid is 2 cycles.
- Redirect priority is redirect over increment.
  - In ISSUE with a handshake in the same cycle: the instruction counts as consumed, PC=redirect_addr, go to FETCH.
  - In ISSUE without a handshake: the pending instruction is dropped (cmd_valid=0 next cycle), PC=redirect_addr, go to FETCH.
  - In FETCH: PC=redirect_addr, the fetched word is discarded, and the stage stays in FETCH to refetch.
  - In IDLE or HALT: redirect is ignored.
- HALT: halted=1 and busy=0. A start pulse loads PC=start_addr and goes to FETCH; halted clears on that edge.
- A start pulse in FETCH or ISSUE is ignored.

Optional Feature:
Macro IFETCH_STEP_EN adds an input step (1 bit), used for single-step debugging.
- Defined: FETCH to ISSUE only advances on a cycle with step=1; otherwise the stage waits in FETCH with PC unchanged. Redirects are still honoured while waiting.
- Not defined: the step port does not exist and FETCH always advances after 1 cycle.

Test Plan:
- Load mem[0..3]={0x0_0,0x5_0,0x4_0,0xF_0}, start_addr=0, cmd_ready=1 -> cmd_op issued 0,5,4,15 with cmd_pc 0,1,2,3, each 2 cycles apart; halted=1 after opcode 15; cmd_valid=0 thereafter.
- Backpressure: cmd_ready=0 for 5 cycles on the instruction at PC=1 -> cmd_valid, cmd_op and cmd_pc stay stable all 5 cycles; the instruction issues once when cmd_ready=1.
- Redirect in ISSUE with handshake: JNZ word 0x8_6 at PC=2, redirect_addr=6 in the handshake cycle -> next cmd_pc=6.
- Redirect in ISSUE without handshake: redirect_addr=9 while cmd_ready=0 -> cmd_valid=0 for 1 cycle, next cmd_pc=9, the dropped instruction is never seen.
- Wrap and mid-run reset: start_addr=15 with mem[15]=0x5_0 -> next cmd_pc=0. Assert reset=0 during ISSUE -> cmd_valid=0 immediately, state IDLE, busy=0.
- prog_we during ISSUE writing 0xF_0 to the next PC -> write ignored; the old memory word issues. In HALT, start with start_addr=0 -> re-runs from 0 and halted clears.
